// File: rtl/piano_judge_pkg.sv
// Shared constants for the piano hit judge: result encoding, default windows, widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package piano_judge_pkg;

    localparam int H_W     = 10;
    localparam int SCORE_W = 14;
    localparam int COMBO_W = 7;

    localparam logic [1:0] KIND_NONE    = 2'b00;
    localparam logic [1:0] KIND_GOOD    = 2'b01;
    localparam logic [1:0] KIND_PERFECT = 2'b10;
    localparam logic [1:0] KIND_MISS    = 2'b11;

    localparam int unsigned PERF_LO_DEF     = 640;
    localparam int unsigned PERF_HI_DEF     = 670;
    localparam int unsigned GOOD_LO_DEF     = 610;
    localparam int unsigned GOOD_HI_DEF     = 700;
    localparam int unsigned MISS_H_DEF      = 720;
    localparam int unsigned PTS_PERFECT_DEF = 3;
    localparam int unsigned PTS_GOOD_DEF    = 1;
    localparam int unsigned FLASH_LEN_DEF   = 8;

endpackage

// File: rtl/lane_judge.sv
// One lane: key edge detect, respawn detect, armed flag, window classification, flash counter.
// Latency: kind registered 1 cycle after the sampled input; kind_nxt is the same-cycle comb value.
// Backpressure: none; stop freezes judging while edge/history tracking keeps running.
module lane_judge import piano_judge_pkg::*; #(
    parameter int unsigned PERF_LO   = PERF_LO_DEF,
    parameter int unsigned PERF_HI   = PERF_HI_DEF,
    parameter int unsigned GOOD_LO   = GOOD_LO_DEF,
    parameter int unsigned GOOD_HI   = GOOD_HI_DEF,
    parameter int unsigned MISS_H    = MISS_H_DEF,
    parameter int unsigned FLASH_LEN = FLASH_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stop,
    input  logic [H_W-1:0] block_h,
    input  logic           key,
    output logic [1:0]     kind_nxt,
    output logic [1:0]     kind,
    output logic           flash
);

    localparam int CW = $clog2(FLASH_LEN + 1);

    logic           key_q, key_d;
    logic [H_W-1:0] h_prev_q, h_prev_d;
    logic           armed_q, armed_d;
    logic [1:0]     kind_q, kind_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic press, spawn, in_perf, in_good;

    always_comb begin
        press   = key & ~key_q;
        spawn   = block_h < h_prev_q;
        in_perf = (block_h >= H_W'(PERF_LO)) && (block_h <= H_W'(PERF_HI));
        in_good = (block_h >= H_W'(GOOD_LO)) && (block_h <= H_W'(GOOD_HI));

        key_d    = key;
        h_prev_d = block_h;
        armed_d  = armed_q;
        kind_d   = KIND_NONE;
        cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

        if (!stop) begin
            // A respawn outranks any press: the old block missed, the lane re-arms.
            if (spawn) begin
                if (armed_q) kind_d = KIND_MISS;
                armed_d = 1'b1;
            end else if (armed_q) begin
                if (press && in_perf) begin
                    kind_d  = KIND_PERFECT;
                    armed_d = 1'b0;
                end else if (press && in_good) begin
                    kind_d  = KIND_GOOD;
                    armed_d = 1'b0;
                end else if (!press && (block_h >= H_W'(MISS_H))) begin
                    kind_d  = KIND_MISS;
                    armed_d = 1'b0;
                end
            end
        end

        if ((kind_d == KIND_PERFECT) || (kind_d == KIND_GOOD)) cnt_d = CW'(FLASH_LEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q    <= 1'b0;
            h_prev_q <= H_W'(MISS_H);
            armed_q  <= 1'b0;
            kind_q   <= KIND_NONE;
            cnt_q    <= '0;
        end else begin
            key_q    <= key_d;
            h_prev_q <= h_prev_d;
            armed_q  <= armed_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
        end
    end

    assign kind_nxt = kind_d;
    assign kind     = kind_q;
    assign flash    = (cnt_q != '0);

endmodule

// File: rtl/lane_hit_judge.sv
// Four-lane hit judge: per-lane PERFECT/GOOD/MISS plus saturating score, combo and max combo.
// Latency: all outputs registered, updated on the edge that samples the key/position change.
// Backpressure: none; stop_or_endgame freezes judging and aggregation.
module lane_hit_judge import piano_judge_pkg::*; #(
    parameter int unsigned PERF_LO     = PERF_LO_DEF,
    parameter int unsigned PERF_HI     = PERF_HI_DEF,
    parameter int unsigned GOOD_LO     = GOOD_LO_DEF,
    parameter int unsigned GOOD_HI     = GOOD_HI_DEF,
    parameter int unsigned MISS_H      = MISS_H_DEF,
    parameter int unsigned PTS_PERFECT = PTS_PERFECT_DEF,
    parameter int unsigned PTS_GOOD    = PTS_GOOD_DEF,
    parameter int unsigned FLASH_LEN   = FLASH_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               stop_or_endgame,
    input  logic [H_W-1:0]     block_h0,
    input  logic [H_W-1:0]     block_h1,
    input  logic [H_W-1:0]     block_h2,
    input  logic [H_W-1:0]     block_h3,
    input  logic [3:0]         key,
    output logic [7:0]         judge_kind,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [3:0]         lane_flash
);

    localparam int SUM_W = SCORE_W + 2;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic                clr;
    logic [H_W-1:0]      h_arr [4];
    logic [3:0][1:0]     kind_nxt;
    logic [3:0][1:0]     kind;

    logic [SCORE_W-1:0]  score_q, score_d;
    logic [COMBO_W-1:0]  combo_q, combo_d;
    logic [COMBO_W-1:0]  max_combo_q, max_combo_d;

    logic [2:0]          n_perf, n_good;
    logic                any_miss;
    logic [SUM_W-1:0]    score_sum;
    logic [COMBO_W:0]    combo_sum;

    assign clr      = rst | restart;
    assign h_arr[0] = block_h0;
    assign h_arr[1] = block_h1;
    assign h_arr[2] = block_h2;
    assign h_arr[3] = block_h3;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        lane_judge #(
            .PERF_LO   (PERF_LO),
            .PERF_HI   (PERF_HI),
            .GOOD_LO   (GOOD_LO),
            .GOOD_HI   (GOOD_HI),
            .MISS_H    (MISS_H),
            .FLASH_LEN (FLASH_LEN)
        ) u_lane (
            .clk      (clk),
            .rst      (clr),
            .stop     (stop_or_endgame),
            .block_h  (h_arr[i]),
            .key      (key[i]),
            .kind_nxt (kind_nxt[i]),
            .kind     (kind[i]),
            .flash    (lane_flash[i])
        );
    end

    // Aggregate from the lanes' next-cycle results so totals move on the same edge as judge_kind.
    always_comb begin
        n_perf   = '0;
        n_good   = '0;
        any_miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kind_nxt[i] == KIND_PERFECT) n_perf = n_perf + 3'd1;
            if (kind_nxt[i] == KIND_GOOD)    n_good = n_good + 3'd1;
            if (kind_nxt[i] == KIND_MISS)    any_miss = 1'b1;
        end

        score_sum = {2'b00, score_q}
                  + SUM_W'(n_perf) * SUM_W'(PTS_PERFECT)
                  + SUM_W'(n_good) * SUM_W'(PTS_GOOD);
        score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

        combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(n_perf) + (COMBO_W+1)'(n_good);
        if (any_miss)                combo_d = '0;
        else if (combo_sum[COMBO_W]) combo_d = '1;
        else                         combo_d = combo_sum[COMBO_W-1:0];

        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
        end else begin
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    assign judge_kind = kind;
    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_combo_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Directed bench for lane_hit_judge with a rule-level reference model and literal spot checks.
module tb_lane_hit_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  h [4];
    logic [3:0]  key = 4'b0;
    logic [7:0]  judge_kind;
    logic [13:0] score;
    logic [6:0]  combo;
    logic [6:0]  max_combo;
    logic [3:0]  lane_flash;

    int tests = 0;
    int fails = 0;

    // reference model state
    int       m_armed [4];
    int       m_key   [4];
    int       m_prev  [4];
    int       m_cnt   [4];
    int       m_score, m_combo, m_max;
    int       m_kind  [4];
    bit       started = 1'b0;

    always #5 clk = ~clk;

    lane_hit_judge dut (
        .clk             (clk),
        .rst             (rst),
        .restart         (restart),
        .stop_or_endgame (stop),
        .block_h0        (h[0]),
        .block_h1        (h[1]),
        .block_h2        (h[2]),
        .block_h3        (h[3]),
        .key             (key),
        .judge_kind      (judge_kind),
        .score           (score),
        .combo           (combo),
        .max_combo       (max_combo),
        .lane_flash      (lane_flash)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arm the masked lanes with a respawn, then press them all at height hv (key left held).
    task automatic hit_round(input logic [3:0] mask, input int hv);
        key = 4'b0;
        for (int i = 0; i < 4; i++) if (mask[i]) h[i] = 10'd120;
        tick();
        for (int i = 0; i < 4; i++) if (mask[i]) h[i] = 10'(hv);
        key = mask;
        tick();
    endtask

    // Model: evaluates the judging rules directly at every clock edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst || restart) begin
                for (int i = 0; i < 4; i++) begin
                    m_armed[i] = 0; m_key[i] = 0; m_prev[i] = 720; m_cnt[i] = 0; m_kind[i] = 0;
                end
                m_score = 0; m_combo = 0; m_max = 0;
            end else begin
                int np, ng, miss;
                np = 0; ng = 0; miss = 0;
                for (int i = 0; i < 4; i++) begin
                    int hv, press;
                    hv = int'(h[i]);
                    press = (key[i] == 1'b1) && (m_key[i] == 0);
                    m_kind[i] = 0;
                    if (!stop) begin
                        if (hv < m_prev[i]) begin
                            if (m_armed[i] != 0) m_kind[i] = 3;
                            m_armed[i] = 1;
                        end else if (m_armed[i] != 0) begin
                            if (press && hv >= 640 && hv <= 670) begin
                                m_kind[i] = 2; m_armed[i] = 0;
                            end else if (press && hv >= 610 && hv <= 700) begin
                                m_kind[i] = 1; m_armed[i] = 0;
                            end else if (!press && hv >= 720) begin
                                m_kind[i] = 3; m_armed[i] = 0;
                            end
                        end
                    end
                    if (m_kind[i] == 1 || m_kind[i] == 2) m_cnt[i] = 8;
                    else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                    if (m_kind[i] == 2) np++;
                    if (m_kind[i] == 1) ng++;
                    if (m_kind[i] == 3) miss = 1;
                    m_key[i] = int'(key[i]);
                    m_prev[i] = hv;
                end
                m_score = m_score + 3 * np + ng;
                if (m_score > 16383) m_score = 16383;
                if (miss) m_combo = 0;
                else m_combo = (m_combo + np + ng > 127) ? 127 : m_combo + np + ng;
                if (m_combo > m_max) m_max = m_combo;
            end
            started = 1'b1;
        end
    end

    // Compare process: every negedge once the model has seen an edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                int ek, ef;
                ek = 0; ef = 0;
                for (int i = 0; i < 4; i++) begin
                    ek = ek | (m_kind[i] << (2 * i));
                    if (m_cnt[i] != 0) ef = ef | (1 << i);
                end
                chk("model judge_kind", int'(judge_kind), ek);
                chk("model score", int'(score), m_score);
                chk("model combo", int'(combo), m_combo);
                chk("model max_combo", int'(max_combo), m_max);
                chk("model lane_flash", int'(lane_flash), ef);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) h[i] = 10'd720;

        // reset
        tick(); tick();
        chk("reset score", int'(score), 0);
        chk("reset judge_kind", int'(judge_kind), 0);
        chk("reset combo", int'(combo), 0);
        chk("reset lane_flash", int'(lane_flash), 0);
        rst = 1'b0;

        // PERFECT on lane 0 after a full ramp
        h[0] = 10'd120; tick();
        for (int v = 121; v <= 649; v++) begin h[0] = 10'(v); tick(); end
        h[0] = 10'd650; key = 4'b0001; tick();
        chk("perfect kind", int'(judge_kind), 8'b0000_0010);
        chk("perfect score", int'(score), 3);
        chk("perfect combo", int'(combo), 1);
        chk("perfect flash", int'(lane_flash), 4'b0001);
        tick();
        chk("kind clears", int'(judge_kind), 0);
        for (int i = 0; i < 6; i++) tick();
        chk("flash 8th cycle", int'(lane_flash), 4'b0001);
        tick();
        chk("flash ends", int'(lane_flash), 0);

        // GOOD on lane 2, then a second press on the disarmed lane
        key = 4'b0; h[2] = 10'd120; tick();
        h[2] = 10'd620; key = 4'b0100; tick();
        chk("good kind", int'(judge_kind), 8'b0001_0000);
        chk("good score", int'(score), 4);
        key = 4'b0; tick();
        h[2] = 10'd630; key = 4'b0100; tick();
        chk("disarmed press kind", int'(judge_kind), 0);
        chk("disarmed press score", int'(score), 4);

        // build combo 5, then MISS on lane 1 after an ignored early press
        for (int r = 0; r < 3; r++) hit_round(4'b1000, 650);
        chk("combo before miss", int'(combo), 5);
        key = 4'b0; h[1] = 10'd120; tick();
        h[1] = 10'd500; key = 4'b0010; tick();
        chk("early press kind", int'(judge_kind), 0);
        key = 4'b0; h[1] = 10'd720; tick();
        chk("miss kind", int'(judge_kind), 8'b0000_1100);
        chk("miss combo", int'(combo), 0);
        chk("miss max_combo", int'(max_combo), 5);
        chk("miss score", int'(score), 13);

        // simultaneous: lanes 0,3 PERFECT with lane 1 MISS, then all four PERFECT
        h[0] = 10'd120; h[1] = 10'd120; h[3] = 10'd120; tick();
        h[0] = 10'd650; h[3] = 10'd650; h[1] = 10'd720; key = 4'b1001; tick();
        chk("mixed kind", int'(judge_kind), 8'b1000_1110);
        chk("mixed score", int'(score), 19);
        chk("mixed combo", int'(combo), 0);
        hit_round(4'b1111, 650);
        chk("quad kind", int'(judge_kind), 8'b1010_1010);
        chk("quad score", int'(score), 31);
        chk("quad combo", int'(combo), 4);

        // freeze
        key = 4'b0; h[0] = 10'd120; tick();
        h[0] = 10'd650; stop = 1'b1; tick();
        key = 4'b0001; tick();
        chk("frozen press kind", int'(judge_kind), 0);
        chk("frozen press score", int'(score), 31);
        stop = 1'b0; tick();
        chk("held after resume", int'(judge_kind), 0);
        key = 4'b0; tick();
        key = 4'b0001; tick();
        chk("press after resume", int'(judge_kind), 8'b0000_0010);
        chk("resume score", int'(score), 34);
        chk("resume combo", int'(combo), 5);

        // saturation
        for (int r = 0; r < 1362; r++) hit_round(4'b1111, 650);
        chk("long score", int'(score), 16378);
        chk("combo saturated", int'(combo), 127);
        chk("max_combo saturated", int'(max_combo), 127);
        key = 4'b0; h[0] = 10'd120; h[1] = 10'd120; tick();
        h[0] = 10'd650; h[1] = 10'd620; key = 4'b0011; tick();
        chk("perf+good kind", int'(judge_kind), 8'b0000_0110);
        chk("score 16382", int'(score), 16382);
        hit_round(4'b0001, 650);
        chk("score clipped", int'(score), 16383);
        chk("combo held 127", int'(combo), 127);

        // restart mid-game
        key = 4'b0; h[2] = 10'd120; tick();
        restart = 1'b1; tick();
        chk("restart score", int'(score), 0);
        chk("restart combo", int'(combo), 0);
        chk("restart max_combo", int'(max_combo), 0);
        chk("restart kind", int'(judge_kind), 0);
        chk("restart flash", int'(lane_flash), 0);
        restart = 1'b0; h[2] = 10'd650; key = 4'b0100; tick();
        chk("post-restart press", int'(judge_kind), 0);
        key = 4'b0; tick();
        key = 4'b0100; tick();
        chk("rearmed perfect", int'(judge_kind), 8'b0010_0000);
        chk("rearmed score", int'(score), 3);
        key = 4'b0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lane_hit_judge.md
Name: lane_hit_judge

Overview:
- Downstream consumer of the four falling-block lane generators.
- Takes each lane's block_h (block vertical position, 120 at spawn, +1 per clk, parks at 720) and the four piano key levels.
- Classifies each block as PERFECT, GOOD or MISS, and maintains score, combo and max combo for the score display.
- Also drives a short per-lane hit-flash signal to the VGA renderer.

Parameters:
- PERF_LO, 640: lowest block_h judged PERFECT (inclusive).
- PERF_HI, 670: highest block_h judged PERFECT (inclusive).
- GOOD_LO, 610: lowest block_h judged GOOD (inclusive); must be <= PERF_LO.
- GOOD_HI, 700: highest block_h judged GOOD (inclusive); must be >= PERF_HI and < MISS_H.
- MISS_H, 720: block_h at which an unjudged block is a MISS.
- PTS_PERFECT, 3: score increment per PERFECT.
- PTS_GOOD, 1: score increment per GOOD.
- FLASH_LEN, 8: lane_flash duration in clk cycles.

Ports:
- clk  in  1  game clock; same clock as the lane generators.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  synchronous game restart; same effect as rst.
- stop_or_endgame  in  1  freeze: no judging, no score/combo change.
- block_h0..block_h3  in  10 each  lane 0..3 block position.
- key  in  4  piano key levels, bit i = lane i; already debounced, 1 = pressed.
- judge_kind  out  8  registered per-lane result for this cycle, 2 bits per lane [2i+1:2i]: 00 none, 01 GOOD, 10 PERFECT, 11 MISS.
- score  out  14  accumulated score; saturates at 16383.
- combo  out  7  consecutive hits since last MISS; saturates at 127.
- max_combo  out  7  highest combo this game.
- lane_flash  out  4  bit i high for FLASH_LEN cycles after a PERFECT or GOOD on lane i.

Behaviour:
Reset and restart
- Reset: rst or restart at a clk edge clears everything. judge_kind=0, score=0, combo=0, max_combo=0, lane_flash=0, all armed flags=0, key_q=0, h_prev=720 per lane.
- Priority: rst/restart > stop_or_endgame > normal operation.

Per-lane detection (each cycle)
- press_i = key[i] & ~key_q[i].
- spawn_i = (block_h_i < h_prev_i).
- key_q and h_prev update every non-reset cycle, including while frozen. A key held through a pause therefore does not fire on resume.

Per-lane judging (skipped entirely while stop_or_endgame=1)
- Respawn while still armed: the old block is a MISS and the lane stays armed for the new block. A press in the same cycle is ignored.
- Respawn while not armed: arm the lane, no result.
- Armed and press with PERF_LO<=h<=PERF_HI: PERFECT, disarm.
- Armed and press with GOOD_LO<=h<=GOOD_HI outside the PERFECT window: GOOD, disarm.
- Armed and press outside the GOOD window: ignored, no penalty, stays armed.
- Armed, no press, h>=MISS_H: MISS, disarm.
- Not armed: no result; presses are ignored.

Output timing
- Outputs are registered. A result appears on judge_kind at the edge that samples the press or the threshold crossing, i.e. 1 cycle after the key/block_h input change.
- judge_kind returns to 00 in the next cycle unless a new event occurs.

Aggregation (same edge, all lanes combined)
- score += PTS_PERFECT*nPerfect + PTS_GOOD*nGood, saturating.
- If any lane MISSes this cycle, combo=0; the cycle's hits still score. Otherwise combo += nPerfect+nGood, saturating at 127.
- max_combo = max(max_combo, new combo value), same edge.

lane_flash
- A per-lane down-counter loads FLASH_LEN on a hit; lane_flash_i = (count != 0).
- A re-hit reloads the counter.
- The counter keeps counting during a freeze.

Decomposition:
- Package piano_judge_pkg holds:
  - the judge_kind encoding constants (NONE, GOOD, PERFECT, MISS);
  - the default window bounds and point values;
  - the SCORE_W=14 and COMBO_W=7 widths.
- Sub-module lane_judge, instantiated 4 times, contains: key edge detect, h_prev/spawn detect, armed flag, window classification, and the flash counter. It outputs a 2-bit kind and the flash bit.
- The top level does the hit counting, score/combo saturation and max_combo.

Test Plan:
- PERFECT: lane 0 spawn (h 720->120), ramp h to 650, key[0] rises -> judge_kind[1:0]=10 next edge, score=3, combo=1, lane_flash[0] high 8 cycles.
- GOOD then ignore: lane 2 press at h=620 -> GOOD, score+1. A second press at h=630 -> none (disarmed).
- MISS: lane 1 armed, no press, h reaches 720 -> kind 11, combo 5->0, max_combo stays 5. An early press at h=500 produces none and no penalty.
- Simultaneous: lanes 0 and 3 PERFECT while lane 1 MISSes in the same cycle -> score+6, combo=0. With all four PERFECT -> score+12, combo+4.
- Freeze: stop_or_endgame=1 with lane armed at h=650, press -> no result. Release the stop while the key is still held -> no result. A new press after release -> PERFECT.
- Saturation and reset: preload score 16382, PERFECT -> score 16383. combo 127 stays 127 on a hit. restart mid-game -> all outputs 0 and lanes unarmed the next edge.
